ps2_rx_deframer: RTL and testbench
==================================

Name: ps2_rx_deframer

Overview:
Receive path of the PS/2 port. This block carries device-to-host frames; the existing output shift register is the transmit path.
- Synchronises and glitch-filters the Ps2Clk/Ps2Data pins.
- Samples Ps2Data on filtered Ps2Clk falling edges and assembles an 11-bit frame: start, 8 data LSB-first, odd parity, stop.
- Delivers the byte with a one-cycle valid strobe, or reports a typed error.
- Sits between the pin pads and the mouse packet decoder.

Parameters:
SYNC_STAGES, 2, flip-flop stages on each pin input (minimum 2)
FILTER_LEN, 4, consecutive equal synchronised Ps2Clk samples needed to change the filtered clock level
TIMEOUT_CYCLES, 5000, maximum Clk cycles between Ps2Clk falling edges inside a frame (100 us at 50 MHz)

Ports:
Clk  in  1  system clock; all logic is on the rising edge
nReset  in  1  reset, asynchronous and active-low
Ps2Clk  in  1  raw PS/2 clock pin (asynchronous)
Ps2Data  in  1  raw PS/2 data pin (asynchronous)
RxEnable  in  1  high = reception allowed; the host drives it low while transmitting or inhibiting
RxData  out  8  last good byte; held until the next good frame
RxValid  out  1  one-cycle pulse: RxData was updated
RxError  out  1  one-cycle pulse: frame rejected
ErrCode  out  2  0 none, 1 bad start, 2 parity, 3 stop/timeout; held until the next RxValid or RxError
Busy  out  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Reset values:
  - RxData=0, RxValid=0, RxError=0, ErrCode=0, Busy=0.
  - Filtered clock=1; synchroniser stages preset to 1; state=IDLE; bit counter=0.
- Input conditioning:
  - Each pin passes through SYNC_STAGES flops.
  - The filtered clock changes level only after FILTER_LEN identical consecutive synchronised samples.
  - Fall = previous filtered 1, current 0. It is a single-cycle internal pulse.
- Sampling: data is sampled from the synchronised Ps2Data in the same cycle as Fall.
- State machine IDLE / SHIFT / CHECK:
  - IDLE + Fall + RxEnable:
    - data=0 -> SHIFT, cnt=0.
    - data=1 -> RxError pulse, ErrCode=1, stay in IDLE.
  - IDLE + Fall + !RxEnable: edge ignored.
  - SHIFT + Fall:
    - Shift data into a 10-bit register, LSB first; cnt++.
    - When cnt reaches 10 (8 data + parity + stop), go to CHECK.
  - CHECK, exactly one cycle, then IDLE:
    - parity_ok = XOR(data[7:0], parity) == 1.
    - stop_ok = (stop == 1).
    - Both ok: RxData <= data, RxValid pulse, ErrCode=0.
    - Stop bad: RxError, ErrCode=3. This takes precedence over a parity error.
    - Parity bad only: RxError, ErrCode=2.
- Latency:
  - RxValid or RxError rises in the second Clk cycle after the Fall that sampled the stop bit (that Fall is cycle 0, CHECK is cycle 1).
  - Pin edge to Fall is SYNC_STAGES+FILTER_LEN cycles.
- RxEnable dropping in SHIFT: return to IDLE next cycle, discard partial data, no error pulse.
- RxValid and RxError are mutually exclusive and never asserted on consecutive frames without a new start bit.
- Reset mid-frame: the asynchronous clear returns everything to reset values immediately. The next frame must begin with a fresh start bit.
- Fall while in CHECK: cannot occur at legal PS/2 rates. If it does, it is ignored.

Optional Feature:
PS2_RX_TIMEOUT_EN
- Defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) clears on every Fall and increments in SHIFT.
  - On reaching TIMEOUT_CYCLES: RxError pulse, ErrCode=3, state -> IDLE.
- Undefined: no counter; a stalled frame stays in SHIFT until RxEnable drops or reset.

Decomposition:
- Shared package ps2_pkg:
  - ErrCode constants ERR_NONE=0, ERR_START=1, ERR_PARITY=2, ERR_STOP=3.
  - FRAME_BITS=11.
  - State encoding for IDLE/SHIFT/CHECK.
  - These are shared with the Tx side and the packet decoder.
- Sub-module ps2_pin_filter: synchroniser plus glitch filter plus fall-edge detect. Instantiated once for Ps2Clk. Ps2Data uses only its synchroniser.

Test Plan:
- Byte 0xA5:
  - Stimulus: frame 0,1,0,1,0,0,1,0,1,P=1,S=1 at 12.5 kHz.
  - Response: RxValid exactly one cycle, RxData=0xA5, ErrCode=0, Busy low after.
- Byte 0x00 with P=0: RxError, ErrCode=2, RxData keeps its prior value 0xA5.
- Byte 0xFF, P=1, S=0: RxError, ErrCode=3 (stop beats parity check).
- Idle line, falling clock edge with data=1: RxError, ErrCode=1, state stays IDLE; a following valid 0x3C frame yields RxValid with 0x3C.
- Glitches and RxEnable:
  - Stimulus: 2-cycle low glitches on Ps2Clk (< FILTER_LEN) during a 0x12 frame.
  - Response: no extra bits, RxData=0x12.
  - Stimulus: RxEnable dropped after 4 bits.
  - Response: no pulse; next frame 0x34 is received correctly.
- With PS2_RX_TIMEOUT_EN:
  - Stimulus: stop Ps2Clk after 5 bits.
  - Response: RxError and ErrCode=3 exactly TIMEOUT_CYCLES (+1 registration) after the last Fall.
  - Stimulus: nReset pulse mid-frame.
  - Response: all outputs 0 immediately.

Source files
------------

// File: rtl/ps2_pkg.sv
// PS/2 shared definitions: frame geometry, error codes, receiver states.
// Used by the receive deframer, the transmit side and the packet decoder.
package ps2_pkg;

  localparam int FRAME_BITS = 11;
  localparam int SHIFT_BITS = FRAME_BITS - 1;

  typedef logic [1:0] err_code_t;

  localparam err_code_t ERR_NONE   = 2'd0;
  localparam err_code_t ERR_START  = 2'd1;
  localparam err_code_t ERR_PARITY = 2'd2;
  localparam err_code_t ERR_STOP   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CHECK = 2'd2
  } rx_state_e;

  typedef struct packed {
    logic       stop;
    logic       parity;
    logic [7:0] data;
  } rx_frame_t;

  function automatic logic odd_parity_ok(
    input logic [7:0] d,
    input logic       p
  );
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_pin_filter.sv
// PS/2 pin conditioning: synchroniser, glitch filter, falling-edge pulse.
// The filtered level moves only after FILTER_LEN equal synchronised samples.
module ps2_pin_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic Clk,
  input  logic nReset,
  input  logic Pin,
  output logic Fall
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_s;
  logic [CW-1:0]          cnt_q;
  logic                   level_q;
  logic                   prev_q;

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], Pin};
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  // cnt_q counts consecutive samples that disagree with the level
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      level_q <= 1'b1;
      prev_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      prev_q <= level_q;
      if (sync_s == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
        level_q <= sync_s;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign Fall = prev_q & ~level_q;

endmodule

// File: rtl/ps2_rx_deframer.sv
// PS/2 device-to-host deframer: start, 8 data LSB-first, odd parity, stop.
// Define PS2_RX_TIMEOUT_EN to abort frames whose clock stalls in SHIFT.
module ps2_rx_deframer
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       Clk,
  input  logic       nReset,
  input  logic       Ps2Clk,
  input  logic       Ps2Data,
  input  logic       RxEnable,
  output logic [7:0] RxData,
  output logic       RxValid,
  output logic       RxError,
  output logic [1:0] ErrCode,
  output logic       Busy
);

  localparam int CNT_W = $clog2(SHIFT_BITS + 1);

  rx_state_e              state_q;
  rx_state_e              state_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [SHIFT_BITS-1:0]  shreg_q;
  rx_frame_t              frame;
  logic [SYNC_STAGES-1:0] dsync_q;
  logic                   data_s;
  logic                   fall;
  logic                   timeout;
  logic                   par_ok;
  logic                   stop_ok;
  logic                   last_bit;
  logic                   rx_load;
  logic                   err_set;
  err_code_t              err_val;

  ps2_pin_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_clk_filter (
    .Clk   (Clk),
    .nReset(nReset),
    .Pin   (Ps2Clk),
    .Fall  (fall)
  );

  // Data is only sampled on clock falls, so no filter is needed here
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      dsync_q <= '1;
    end else begin
      dsync_q <= {dsync_q[SYNC_STAGES-2:0], Ps2Data};
    end
  end

  assign data_s   = dsync_q[SYNC_STAGES-1];
  assign frame    = rx_frame_t'(shreg_q);
  assign par_ok   = odd_parity_ok(frame.data, frame.parity);
  assign stop_ok  = frame.stop;
  assign last_bit = (cnt_q == CNT_W'(SHIFT_BITS - 1));

`ifdef PS2_RX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_q;

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      to_q <= '0;
    end else if (fall || state_q != ST_SHIFT) begin
      to_q <= '0;
    end else if (to_q != TO_W'(TIMEOUT_CYCLES)) begin
      to_q <= to_q + 1'b1;
    end
  end

  assign timeout = (state_q == ST_SHIFT)
                && (to_q == TO_W'(TIMEOUT_CYCLES));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (fall && RxEnable && !data_s) begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (!RxEnable || timeout) begin
          state_d = ST_IDLE;
        end else if (fall && last_bit) begin
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Conditions below are mutually exclusive by state; stop beats parity
  always_comb begin
    rx_load = 1'b0;
    err_set = 1'b0;
    err_val = ERR_NONE;
    Busy    = (state_q != ST_IDLE);
    unique case (1'b1)
      (state_q == ST_IDLE) && fall && RxEnable && data_s: begin
        err_set = 1'b1;
        err_val = ERR_START;
      end
      (state_q == ST_SHIFT) && RxEnable && timeout: begin
        err_set = 1'b1;
        err_val = ERR_STOP;
      end
      (state_q == ST_CHECK) && !stop_ok: begin
        err_set = 1'b1;
        err_val = ERR_STOP;
      end
      (state_q == ST_CHECK) && stop_ok && !par_ok: begin
        err_set = 1'b1;
        err_val = ERR_PARITY;
      end
      (state_q == ST_CHECK) && stop_ok && par_ok: begin
        rx_load = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      cnt_q   <= '0;
      shreg_q <= '0;
    end else if (state_q != ST_SHIFT) begin
      cnt_q <= '0;
    end else if (fall && RxEnable) begin
      cnt_q   <= cnt_q + 1'b1;
      shreg_q <= {data_s, shreg_q[SHIFT_BITS-1:1]};
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      RxData  <= '0;
      RxValid <= 1'b0;
      RxError <= 1'b0;
      ErrCode <= ERR_NONE;
    end else begin
      RxValid <= rx_load;
      RxError <= err_set;
      if (rx_load) begin
        RxData  <= frame.data;
        ErrCode <= ERR_NONE;
      end else if (err_set) begin
        ErrCode <= err_val;
      end
    end
  end

endmodule

// File: tb/tb_ps2_rx_deframer.sv
// Scoreboard bench for ps2_rx_deframer: random and directed PS/2 frames.
// Expected results come from frame-level rules applied to each sent frame.
module tb_ps2_rx_deframer;

  localparam int H  = 20;
  localparam int TO = 5000;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       ps2_clk  = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rx_en    = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_error;
  logic [1:0] err_code;
  logic       busy;

  always #5 clk = ~clk;

  ps2_rx_deframer #(
    .SYNC_STAGES   (2),
    .FILTER_LEN    (4),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .Clk     (clk),
    .nReset  (rst_n),
    .Ps2Clk  (ps2_clk),
    .Ps2Data (ps2_data),
    .RxEnable(rx_en),
    .RxData  (rx_data),
    .RxValid (rx_valid),
    .RxError (rx_error),
    .ErrCode (err_code),
    .Busy    (busy)
  );

  typedef struct packed {
    logic       err;
    logic [1:0] code;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  int         tests      = 0;
  int         fails      = 0;
  logic [7:0] last_good  = 8'h00;
  logic       prev_pulse = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame-level rules: bad start, then stop, then odd parity over 9 bits
  function automatic exp_t model(input bit start, input logic [7:0] d,
                                 input bit p, input bit s);
    exp_t e;
    e.data = d;
    e.err  = 1'b1;
    if (start)                           e.code = 2'd1;
    else if (!s)                         e.code = 2'd3;
    else if ((($countones(d) + int'(p)) % 2) != 1) e.code = 2'd2;
    else begin
      e.err  = 1'b0;
      e.code = 2'd0;
    end
    return e;
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst_n) begin
      prev_pulse = 1'b0;
    end else begin
      if (rx_valid || rx_error) begin
        chk("pulse_excl", 32'(rx_valid && rx_error), 32'd0);
        chk("pulse_width", 32'(prev_pulse), 32'd0);
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_pulse: got valid=%0b error=%0b expected none",
                   rx_valid, rx_error);
        end else begin
          e = sb.pop_front();
          chk("kind", 32'(rx_error), 32'(e.err));
          chk("errcode", 32'(err_code), 32'(e.code));
          if (!e.err) begin
            chk("rxdata", 32'(rx_data), 32'(e.data));
            last_good = e.data;
          end else begin
            chk("rxdata_hold", 32'(rx_data), 32'(last_good));
          end
        end
      end
      prev_pulse = rx_valid || rx_error;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input bit b, input bit glitch);
    ps2_data = b;
    if (glitch) begin
      wait_cyc(5);
      ps2_clk = 1'b0;
      wait_cyc(2);
      ps2_clk = 1'b1;
      wait_cyc(H - 7);
    end else begin
      wait_cyc(H);
    end
    ps2_clk = 1'b0;
    wait_cyc(H);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit p,
                            input bit s, input bit glitch);
    sb.push_back(model(1'b0, d, p, s));
    send_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) send_bit(d[i], glitch);
    send_bit(p, glitch);
    send_bit(s, glitch);
    ps2_data = 1'b1;
    wait_cyc(4 * H);
    chk("busy_after_frame", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [7:0] d;
    bit         p;
    bit         s;
    int         r;

    wait_cyc(3);
    chk("reset_rxdata", 32'(rx_data), 32'd0);
    chk("reset_valid", 32'(rx_valid), 32'd0);
    chk("reset_error", 32'(rx_error), 32'd0);
    chk("reset_errcode", 32'(err_code), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    wait_cyc(5);

    send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
    send_frame(8'h00, 1'b0, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0);

    sb.push_back(model(1'b1, 8'h00, 1'b0, 1'b1));
    send_bit(1'b1, 1'b0);
    wait_cyc(4 * H);
    chk("busy_after_bad_start", 32'(busy), 32'd0);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b0);

    send_frame(8'h12, 1'b1, 1'b1, 1'b1);

    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    rx_en = 1'b0;
    wait_cyc(3);
    chk("busy_after_disable", 32'(busy), 32'd0);
    wait_cyc(2 * H);
    rx_en = 1'b1;
    wait_cyc(H);
    send_frame(8'h34, 1'b0, 1'b1, 1'b0);

    for (int n = 0; n < 24; n++) begin
      d = 8'($urandom);
      r = int'($urandom_range(0, 9));
      p = ~(^d);
      if (r == 0) p = ~p;
      s = (r == 1) ? 1'b0 : 1'b1;
      send_frame(d, p, s, r >= 8);
    end

`ifdef PS2_RX_TIMEOUT_EN
    sb.push_back(model(1'b0, 8'h00, 1'b1, 1'b0));
    for (int i = 0; i < 5; i++) send_bit(i[0], 1'b0);
    for (int i = 0; i < TO + 200 && sb.size() != 0; i++) wait_cyc(1);
    chk("timeout_pulse_seen", 32'(sb.size()), 32'd0);
    chk("busy_after_timeout", 32'(busy), 32'd0);
    ps2_data = 1'b1;
    wait_cyc(2 * H);
`endif

    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midreset_rxdata", 32'(rx_data), 32'd0);
    chk("midreset_valid", 32'(rx_valid), 32'd0);
    chk("midreset_error", 32'(rx_error), 32'd0);
    chk("midreset_errcode", 32'(err_code), 32'd0);
    chk("midreset_busy", 32'(busy), 32'd0);
    last_good = 8'h00;
    ps2_data  = 1'b1;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(2 * H);
    send_frame(8'h5A, 1'b1, 1'b1, 1'b0);

    for (int i = 0; i < 500 && sb.size() != 0; i++) wait_cyc(1);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
